// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared types and defaults for the gauss window/blur pipeline
package gauss_pkg;
  localparam int DEFAULT_IMAGE_WIDTH  = 128;
  localparam int DEFAULT_IMAGE_HEIGHT = 128;
  localparam int DEFAULT_PIXEL_W      = 8;

  typedef logic [DEFAULT_PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } win_state_e;

  typedef pixel_t window_t [9];
endpackage

// File: rtl/gauss_line_buffer.sv
// rtl/gauss_line_buffer.sv - two-row, column-addressed, read-before-write line store
module gauss_line_buffer #(
  parameter int IMAGE_WIDTH = 128,
  parameter int PIXEL_W     = 8,
  parameter int COL_W       = $clog2(IMAGE_WIDTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   col,
  input  logic [PIXEL_W-1:0] wr_pixel,
  output logic [PIXEL_W-1:0] rd_row1,
  output logic [PIXEL_W-1:0] rd_row2
);
  // Each entry holds {row r-1, row r-2} for its column; contents are never reset.
  logic [2*PIXEL_W-1:0] mem_q [IMAGE_WIDTH];
  logic [2*PIXEL_W-1:0] wr_word_d;

  assign {rd_row1, rd_row2} = mem_q[col];

  always_comb begin
    wr_word_d = {wr_pixel, rd_row1};
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[col] <= wr_word_d;
  end
endmodule

// File: rtl/gauss_window_gen.sv
// rtl/gauss_window_gen.sv - raster stream to 3x3 windows with zero padding;
// defining WINDOW_BORDER_REPLICATE_EN switches the border to edge replicate.
module gauss_window_gen
  import gauss_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int PIXEL_W      = DEFAULT_PIXEL_W
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] win_pixel_1,
  output logic [PIXEL_W-1:0] win_pixel_2,
  output logic [PIXEL_W-1:0] win_pixel_3,
  output logic [PIXEL_W-1:0] win_pixel_4,
  output logic [PIXEL_W-1:0] win_pixel_5,
  output logic [PIXEL_W-1:0] win_pixel_6,
  output logic [PIXEL_W-1:0] win_pixel_7,
  output logic [PIXEL_W-1:0] win_pixel_8,
  output logic [PIXEL_W-1:0] win_pixel_9,
  output logic               out_last
);
  localparam int CNT_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1);
  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam logic [CNT_W-1:0] CNT_FILL_END = CNT_W'(IMAGE_WIDTH+1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(IMAGE_WIDTH*IMAGE_HEIGHT-1);
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMAGE_WIDTH-1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMAGE_HEIGHT-1);

  win_state_e         state_q, state_d;
  logic               rdy_en_q;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [COL_W-1:0]   in_col_q, in_col_d;
  logic [COL_W-1:0]   cen_col_q, cen_col_d;
  logic [ROW_W-1:0]   cen_row_q, cen_row_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [PIXEL_W-1:0] arr_q [3][3];
  logic [PIXEL_W-1:0] arr_d [3][3];
  logic [PIXEL_W-1:0] row_m [3][3];
  logic [PIXEL_W-1:0] win_q [3][3];
  logic [PIXEL_W-1:0] win_d [3][3];
  logic               can_load, accept, shift, emit, frame_done;
  logic [PIXEL_W-1:0] new_pix, lb_row1, lb_row2;

  always_comb begin
    can_load = !out_valid_q || out_ready;
    in_ready = 1'b0;
    if (rdy_en_q) begin
      if (state_q == FILL)     in_ready = 1'b1;
      else if (state_q == RUN) in_ready = can_load;
    end
  end

  // DRAIN keeps shifting zeros until the window flagged last is loaded.
  assign accept     = in_valid && in_ready;
  assign shift      = accept || (state_q == DRAIN && can_load && !(out_valid_q && out_last_q));
  assign emit       = shift && (state_q != FILL || in_cnt_q == CNT_FILL_END);
  assign frame_done = (state_q == DRAIN) && out_valid_q && out_last_q && out_ready;
  assign new_pix    = (state_q == DRAIN) ? '0 : in_pixel;

  gauss_line_buffer #(.IMAGE_WIDTH(IMAGE_WIDTH), .PIXEL_W(PIXEL_W), .COL_W(COL_W)) u_line_buffer (
    .clk      (clk),
    .wr_en    (shift),
    .col      (in_col_q),
    .wr_pixel (new_pix),
    .rd_row1  (lb_row1),
    .rd_row2  (lb_row2)
  );

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    in_col_d  = in_col_q;
    cen_col_d = cen_col_q;
    cen_row_d = cen_row_q;
    if (accept) in_cnt_d = in_cnt_q + CNT_W'(1);
    if (shift)  in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + COL_W'(1);
    if (emit) begin
      if (cen_col_q == COL_LAST) begin
        cen_col_d = '0;
        cen_row_d = cen_row_q + ROW_W'(1);
      end else begin
        cen_col_d = cen_col_q + COL_W'(1);
      end
    end
    case (state_q)
      FILL: begin
        if (accept && in_cnt_q == CNT_LAST)          state_d = DRAIN;
        else if (accept && in_cnt_q == CNT_FILL_END) state_d = RUN;
      end
      RUN: if (accept && in_cnt_q == CNT_LAST) state_d = DRAIN;
      DRAIN: begin
        if (frame_done) begin
          state_d   = FILL;
          in_cnt_d  = '0;
          in_col_d  = '0;
          cen_col_d = '0;
          cen_row_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Shifted array: centre is always the middle cell; wrapped neighbours are masked below.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) arr_d[r][c] = arr_q[r][c];
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        arr_d[r][0] = arr_q[r][1];
        arr_d[r][1] = arr_q[r][2];
      end
      arr_d[0][2] = lb_row2;
      arr_d[1][2] = lb_row1;
      arr_d[2][2] = new_pix;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) row_m[r][c] = arr_d[r][c];
    for (int c = 0; c < 3; c++) begin
`ifdef WINDOW_BORDER_REPLICATE_EN
      if (cen_row_q == '0)      row_m[0][c] = arr_d[1][c];
      if (cen_row_q == ROW_LAST) row_m[2][c] = arr_d[1][c];
`else
      if (cen_row_q == '0)      row_m[0][c] = '0;
      if (cen_row_q == ROW_LAST) row_m[2][c] = '0;
`endif
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) win_d[r][c] = row_m[r][c];
`ifdef WINDOW_BORDER_REPLICATE_EN
      if (cen_col_q == '0)      win_d[r][0] = row_m[r][1];
      if (cen_col_q == COL_LAST) win_d[r][2] = row_m[r][1];
`else
      if (cen_col_q == '0)      win_d[r][0] = '0;
      if (cen_col_q == COL_LAST) win_d[r][2] = '0;
`endif
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = (cen_row_q == ROW_LAST) && (cen_col_q == COL_LAST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= FILL;
      rdy_en_q    <= 1'b0;
      in_cnt_q    <= '0;
      in_col_q    <= '0;
      cen_col_q   <= '0;
      cen_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          arr_q[r][c] <= '0;
          win_q[r][c] <= '0;
        end
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      in_cnt_q    <= in_cnt_d;
      in_col_q    <= in_col_d;
      cen_col_q   <= cen_col_d;
      cen_row_q   <= cen_row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          arr_q[r][c] <= arr_d[r][c];
          if (emit) win_q[r][c] <= win_d[r][c];
        end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign win_pixel_1 = win_q[0][0];
  assign win_pixel_2 = win_q[0][1];
  assign win_pixel_3 = win_q[0][2];
  assign win_pixel_4 = win_q[1][0];
  assign win_pixel_5 = win_q[1][1];
  assign win_pixel_6 = win_q[1][2];
  assign win_pixel_7 = win_q[2][0];
  assign win_pixel_8 = win_q[2][1];
  assign win_pixel_9 = win_q[2][2];
endmodule

// File: doc/gauss_window_gen.md
# gauss_window_gen

Streaming 3x3 window generator that turns a raster-order pixel stream into the nine-pixel neighbourhoods consumed by `gauss_blur`. It sits directly upstream of `gauss_blur` and produces one window per image pixel, in raster order, on `win_pixel_1..9`. Out-of-image neighbours are zero-padded, matching the golden blur model. Two line buffers and a 3x3 register array replace the frame buffer that a software model would use.

## Interface
- `IMAGE_WIDTH`, 128, pixels per row (>= 2)
- `IMAGE_HEIGHT`, 128, rows per frame (>= 2)
- `PIXEL_W`, 8, bits per pixel
- `clk`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_pixel` is valid
- `in_ready`  out  1  block accepts `in_pixel` this cycle
- `in_pixel`  in  PIXEL_W  raster-order input pixel
- `out_valid`  out  1  window is valid
- `out_ready`  in  1  downstream takes the window this cycle
- `win_pixel_1`..`win_pixel_9`  out  PIXEL_W each  3x3 window, row-major; `_1` is top-left, `_5` is centre, `_9` is bottom-right
- `out_last`  out  1  qualifies the final window of the frame (centre at row H-1, column W-1)

## Operation
- Accept happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- `in_cnt` counts accepted pixels (0..W*H-1). `out_cnt` counts emitted windows. The centre of window k is at row k/W, column k%W.
- FSM states:
  - **FILL**: `in_ready`=1, no output. After the accept with `in_cnt`=W+1, go to **RUN**.
  - **RUN**: each accept emits exactly one window. After the accept of the last pixel (W*H-1), go to **DRAIN**.
  - **DRAIN**: `in_ready`=0. Emit the remaining W+1 windows, with zeros fed in as the "incoming" pixels. After the transfer with `out_last`, go to **FILL**, clear both counters, and start the next frame.
- Line buffers: a two-row store, W entries x 2*PIXEL_W. It is read before write at column c: it returns rows r-1 and r-2, then writes rows r and r-1.
- Border masking uses the centre coordinates. Force to 0:
  - row -1 when centre row = 0
  - row +1 when centre row = H-1
  - column -1 when centre column = 0
  - column +1 when centre column = W-1
- Masking replaces wrap-around data from the previous row or frame. Never expose stale data.
- Counter widths are $clog2(W*H+1). Pixels are passed through unchanged, with no arithmetic.

## Timing
- Reset values: `in_ready`=0 while `Reset`=0 and 1 from the first edge after release; `out_valid`=0, `out_last`=0, all `win_pixel_*`=0. State is FILL and counters are 0. Line-buffer contents are don't-care (masked).
- Latency: `out_valid` rises the cycle after the accept of pixel index W+1. Windows are registered outputs.
- Throughput: 1 window/cycle in RUN and DRAIN with no stalls.
- In RUN, `in_ready = !out_valid || out_ready`.
- Backpressure: while `out_valid && !out_ready`, the window and `out_last` hold stable and no input is accepted.
- `in_valid` low in RUN: `out_valid` drops after the current transfer, and no bubble windows are produced.
- Reset asserted mid-frame: all partial state is discarded immediately. The next accepted pixel is treated as (0,0).

## Configuration
- `WINDOW_BORDER_REPLICATE_EN` defined: out-of-image neighbours take the nearest in-image pixel (edge replicate), applied to rows first, then columns, so corners replicate the corner pixel.
- `WINDOW_BORDER_REPLICATE_EN` undefined (default): zero padding, bit-exact with the `gauss_blur` golden output.

## Structure
- Shared package `gauss_pkg`:
  - `pixel_t` (PIXEL_W-bit logic)
  - `win_state_e` (FILL/RUN/DRAIN)
  - `window_t` (pixel_t array [9])
  - default IMAGE_WIDTH/IMAGE_HEIGHT constants
- Sub-module `gauss_line_buffer`: single-clock, W-deep, two-row read-before-write store, addressed by input column.
- Top level: FSM, counters, 3x3 shift array, border mask and handshake.

## Test plan
- W=H=4, pixels 1..16 streamed back-to-back with `out_ready`=1:
  - first `out_valid` the cycle after the 6th accept
  - 16 windows total, with `out_last` only on the 16th
  - window 0 = {0,0,0,0,1,2,0,5,6}
- Same frame, window 5 (centre 6) = {1,2,3,5,6,7,9,10,11}. Window 15 = {11,12,0,15,16,0,0,0,0}.
- Hold `out_ready`=0 for 5 cycles mid-RUN: the window stays stable, `in_ready`=0, and no accepts occur. After release, the sequence continues with no loss or duplicates.
- Assert `Reset` low after 9 accepts, then resend the full frame: output is identical to the first test, with no stale data.
- With `WINDOW_BORDER_REPLICATE_EN`, the same 4x4 frame gives window 0 = {1,1,2,1,1,2,5,5,6} and window 15 = {11,12,12,15,16,16,15,16,16}.
- Two frames back-to-back, the second being 101..116: window 0 of frame 2 = {0,0,0,0,101,102,0,105,106}, and `in_ready` returns high after frame 1's `out_last`.
